// File: rtl/tx_ser_ctrl_pkg.sv
// Shared types and helpers for the TX serializer controller.
package tx_ser_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_ser_state_t;

  // Width of the mux-tree select for a given word width.
  function automatic int sel_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/tx_ser_ctrl_if.sv
// Parallel-word valid/ready handshake from the link-layer TX FIFO.
interface tx_ser_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/tx_ser_ctrl_skid.sv
// One-entry shadow register: holds the next word while the current one shifts out.
module tx_ser_skid #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full
);

  // Push wins over pop so a same-edge refill and reload leaves the entry full.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dout <= '0;
      full <= 1'b0;
    end else begin
      if (push) dout <= din;
      if (push)     full <= 1'b1;
      else if (pop) full <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_ser_ctrl.sv
// TX mux-tree serializer controller: buffers one word ahead and streams
// words LSB-first with no bubble between consecutive words.
module tx_ser_ctrl
  import tx_ser_pkg::*;
#(
  parameter int   WIDTH    = 16,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     en,
  tx_ser_ctrl_if.slave             feed,
  output logic [sel_w(WIDTH)-1:0]  sel,
  output logic                     out_bit,
  output logic                     out_valid,
  output logic                     word_done,
  output logic                     underflow,
  input  logic                     clr_err
);

  tx_ser_state_t    state, state_nxt;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic             shadow_full;
  logic             push, load, set_uf, last;

  // Ready is held low during reset so nothing is accepted while the block is cleared.
  assign feed.in_ready = rstb && !shadow_full;
  assign push          = feed.in_valid && feed.in_ready;
  // WIDTH is a power of 2, so the last bit index is all ones.
  assign last          = &sel;

  tx_ser_skid #(.WIDTH(WIDTH)) u_skid (
    .clk  (clk),
    .rstb (rstb),
    .push (push),
    .pop  (load),
    .din  (feed.in_data),
    .dout (shadow),
    .full (shadow_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: leave RUN only at a word boundary, so words are never truncated.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && shadow_full) state_nxt = RUN;
      RUN:     if (last && !(en && shadow_full)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: load strobe, stream flags and underflow detection.
  always_comb begin
    load      = 1'b0;
    out_valid = 1'b0;
    word_done = 1'b0;
    set_uf    = 1'b0;
    case (state)
      IDLE: load = en && shadow_full;
      RUN: begin
        out_valid = 1'b1;
        word_done = last;
        load      = last && en && shadow_full;
        set_uf    = last && en && !shadow_full;
      end
      default: ;
    endcase
  end

  // Active word and bit select; the select wraps from last to 0 by overflow.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      active <= '0;
      sel    <= '0;
    end else if (load) begin
      active <= shadow;
      sel    <= '0;
    end else if (state == RUN) begin
      sel    <= sel + 1'b1;
    end
  end

  // Sticky underflow; a fresh underflow beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)        underflow <= 1'b0;
    else if (set_uf)  underflow <= 1'b1;
    else if (clr_err) underflow <= 1'b0;
  end

  assign out_bit = out_valid ? active[sel] : IDLE_BIT;

endmodule

// File: tb/tb_tx_ser_ctrl.sv
// Directed bench for tx_ser_ctrl at WIDTH=8, IDLE_BIT=0.
module tb_tx_ser_ctrl;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] sel;
  logic       out_bit, out_valid, word_done, underflow;
  int         n_cmp = 0;
  int         n_err = 0;

  tx_ser_ctrl_if #(.WIDTH(8)) bus ();

  tx_ser_ctrl #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .en        (en),
    .feed      (bus),
    .sel       (sel),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .word_done (word_done),
    .underflow (underflow),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #2;
    n_cmp++; if (in_ready_now() !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_bit !== 1'b0) begin n_err++; $display("FAIL rst_out_bit got %b want 0", out_bit); end
    n_cmp++; if (sel !== 3'd0) begin n_err++; $display("FAIL rst_sel got %0d want 0", sel); end
    n_cmp++; if (underflow !== 1'b0 || word_done !== 1'b0) begin n_err++; $display("FAIL rst_flags got uf=%b wd=%b want 0 0", underflow, word_done); end
    tick();
    tick();
    rstb = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b want 1", bus.in_ready); end
  endtask

  function automatic logic in_ready_now();
    return bus.in_ready;
  endfunction

  task automatic test_single();
    logic [7:0] w;
    w = 8'hA5;
    en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL single_accept got ov=%b rdy=%b want 0 0", out_valid, bus.in_ready); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || sel !== 3'(i) || out_bit !== w[i] || word_done !== (i == 7)) begin
        n_err++;
        $display("FAIL single_bit%0d got ov=%b sel=%0d bit=%b wd=%b want 1 %0d %b %b", i, out_valid, sel, out_bit, word_done, i, w[i], (i == 7));
      end
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || underflow !== 1'b1 || out_bit !== 1'b0) begin n_err++; $display("FAIL single_end got ov=%b uf=%b bit=%b want 0 1 0", out_valid, underflow, out_bit); end
  endtask

  task automatic test_sticky();
    // clear an existing underflow
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL sticky_clear got %b want 0", underflow); end
    // fresh underflow with clr_err on the same edge
    en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++; if (word_done !== 1'b1 || underflow !== 1'b0) begin n_err++; $display("FAIL sticky_lastbit got wd=%b uf=%b want 1 0", word_done, underflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL sticky_set_wins got %b want 1", underflow); end
    tick();
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL sticky_hold got %b want 1", underflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL sticky_clear2 got %b want 0", underflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic [7:0] w;
    int idx, bits, gaps;
    logic fire;
    words[0] = 8'h0F; words[1] = 8'hF0; words[2] = 8'h3C;
    idx = 0; bits = 0; gaps = 0;
    en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = words[0];
    for (int c = 0; c < 40 && bits < 24; c++) begin
      fire = bus.in_valid && bus.in_ready;
      tick();
      if (fire) begin
        idx++;
        if (idx == 3) bus.in_valid = 1'b0;
        else          bus.in_data  = words[idx];
      end
      if (out_valid) begin
        w = words[bits / 8];
        n_cmp++;
        if (out_bit !== w[bits % 8] || word_done !== ((bits % 8) == 7) || underflow !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_bit%0d got bit=%b wd=%b uf=%b want %b %b 0", bits, out_bit, word_done, underflow, w[bits % 8], ((bits % 8) == 7));
        end
        bits++;
      end else if (bits > 0) begin
        gaps++;
      end
    end
    n_cmp++; if (bits !== 24 || gaps !== 0) begin n_err++; $display("FAIL b2b_stream got bits=%0d gaps=%0d want 24 0", bits, gaps); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || underflow !== 1'b1) begin n_err++; $display("FAIL b2b_end got ov=%b uf=%b want 0 1", out_valid, underflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_graceful_stop();
    logic [7:0] w2;
    w2 = 8'h81;
    en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    tick();
    bus.in_data = w2;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 1) bus.in_valid = 1'b0;
      if (i == 3) en = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_bit !== 1'b1 || sel !== 3'(i)) begin
        n_err++;
        $display("FAIL stop_bit%0d got ov=%b bit=%b sel=%0d want 1 1 %0d", i, out_valid, out_bit, sel, i);
      end
    end
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0 || underflow !== 1'b0 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stop_idle got ov=%b uf=%b rdy=%b want 0 0 0", out_valid, underflow, bus.in_ready); end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_bit !== w2[i]) begin
        n_err++;
        $display("FAIL stop_resume_bit%0d got ov=%b bit=%b want 1 %b", i, out_valid, out_bit, w2[i]);
      end
    end
    tick();
    n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL stop_resume_uf got %b want 1", underflow); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    tick();
    bus.in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) bus.in_valid = 1'b0;
    end
    n_cmp++; if (sel !== 3'd4 || out_bit !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre got sel=%0d bit=%b ov=%b want 4 1 1", sel, out_bit, out_valid); end
    rstb = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_bit !== 1'b0 || bus.in_ready !== 1'b0 || sel !== 3'd0) begin n_err++; $display("FAIL rmid_async got ov=%b bit=%b rdy=%b sel=%0d want 0 0 0 0", out_valid, out_bit, bus.in_ready, sel); end
    tick();
    rstb = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1 || underflow !== 1'b0) begin n_err++; $display("FAIL rmid_release got rdy=%b uf=%b want 1 0", bus.in_ready, underflow); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_idle%0d got ov=%b want 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    int accepted;
    logic fire;
    w = 8'h96;
    en = 1'b0;
    accepted = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hEE;
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_novalid got rdy=%b want 1", bus.in_ready); end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int i = 0; i < 6; i++) begin
      fire = bus.in_valid && bus.in_ready;
      tick();
      if (fire) begin accepted++; bus.in_data = 8'h11; end
      n_cmp++; if (out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d got ov=%b rdy=%b want 0 0", i, out_valid, bus.in_ready); end
    end
    n_cmp++; if (accepted !== 1) begin n_err++; $display("FAIL bp_accepted got %0d want 1", accepted); end
    bus.in_valid = 1'b0;
    en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_bit !== w[i]) begin
        n_err++;
        $display("FAIL bp_bit%0d got ov=%b bit=%b want 1 %b", i, out_valid, out_bit, w[i]);
      end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0 || underflow !== 1'b1) begin n_err++; $display("FAIL bp_end got ov=%b uf=%b want 0 1", out_valid, underflow); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sticky();
    test_back_to_back();
    test_graceful_stop();
    test_reset_mid();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
